// File: rtl/hack_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module      : hack_ctrl_pkg
// Description : Shared state encoding and command bytes for the Hack run
//               controller.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package hack_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        CNT_HI = 4'd1,
        CNT_LO = 4'd2,
        DAT_HI = 4'd3,
        DAT_LO = 4'd4,
        BP_HI  = 4'd5,
        BP_LO  = 4'd6,
        RUN    = 4'd7,
        HALT   = 4'd8,
        STEP   = 4'd9
    } state_t;

    localparam logic [7:0] c_CMD_LOAD  = 8'h4C;
    localparam logic [7:0] c_CMD_BP    = 8'h42;
    localparam logic [7:0] c_CMD_RUN   = 8'h52;
    localparam logic [7:0] c_CMD_STEP  = 8'h53;
    localparam logic [7:0] c_CMD_HALT  = 8'h48;
    localparam logic [7:0] c_CMD_CLRBP = 8'h43;

endpackage

`default_nettype wire

// File: rtl/byte_timeout.sv
//------------------------------------------------------------------------------
// Module      : byte_timeout
// Description : Saturating idle counter; expired flags TIMEOUT idle cycles.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module byte_timeout #(
    parameter int TIMEOUT = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int              c_CW    = $clog2(TIMEOUT + 1);
    localparam logic [c_CW-1:0] c_LIMIT = c_CW'(TIMEOUT);

    logic [c_CW-1:0] r_count;

    // Held at zero while disabled so every multi-byte phase starts fresh.
    always_ff @(posedge clk) begin
        if (reset || clear || !enable) begin
            r_count <= '0;
        end else if (r_count != c_LIMIT) begin
            r_count <= r_count + c_CW'(1);
        end
    end

    assign expired = enable && (r_count == c_LIMIT);

endmodule

`default_nettype wire

// File: rtl/hack_run_ctrl.sv
//------------------------------------------------------------------------------
// Module      : hack_run_ctrl
// Description : Byte-command controller that loads the Hack instruction ROM
//               and runs, halts, steps and breakpoints the CPU.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module hack_run_ctrl #(
    parameter int ROM_AW  = 15,
    parameter int TIMEOUT = 100000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic [15:0]       cpu_pc,
    output logic              cpu_reset,
    output logic              cpu_ce,
    output logic              rom_we,
    output logic [ROM_AW-1:0] rom_addr,
    output logic [15:0]       rom_wdata,
    output logic              loaded,
    output logic              running,
    output logic              halted,
    output logic              load_err,
    output logic              bp_hit
);

    import hack_ctrl_pkg::*;

    state_t              r_state, w_nextState;
    logic [7:0]          r_hiByte;
    logic [15:0]         r_wordCnt, r_wordIdx, r_bpAddr;
    logic                r_bpEn, r_bpFromHalt, r_resume;
    logic                r_loaded, r_loadErr, r_romWe, r_bpHit;
    logic [ROM_AW-1:0]   r_romAddr;
    logic [15:0]         r_romWdata;

    logic w_inLoad, w_inBp, w_expired, w_timeoutAbort, w_bpMatch, w_lastWord, w_inRange;

    assign w_inLoad       = (r_state == CNT_HI) || (r_state == CNT_LO) ||
                            (r_state == DAT_HI) || (r_state == DAT_LO);
    assign w_inBp         = (r_state == BP_HI) || (r_state == BP_LO);
    assign w_timeoutAbort = w_expired && !rx_valid;
    // The first RUN cycle after a resume skips the compare so the CPU steps off the breakpoint.
    assign w_bpMatch      = (r_state == RUN) && r_bpEn && !r_resume && (cpu_pc == r_bpAddr);
    assign w_lastWord     = (r_wordIdx == r_wordCnt - 16'd1);
    assign w_inRange      = ((r_wordIdx >> ROM_AW) == 16'd0);

    byte_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (rx_valid),
        .enable  (w_inLoad || w_inBp),
        .expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE, HALT: begin
                if (rx_valid) begin
                    case (rx_data)
                        c_CMD_LOAD: w_nextState = CNT_HI;
                        c_CMD_BP:   w_nextState = BP_HI;
                        c_CMD_RUN:  w_nextState = RUN;
                        c_CMD_STEP: w_nextState = STEP;
                        default:    w_nextState = r_state;
                    endcase
                end
            end
            CNT_HI: if (rx_valid) w_nextState = CNT_LO;
            CNT_LO: if (rx_valid) w_nextState = ({r_hiByte, rx_data} == 16'd0) ? IDLE : DAT_HI;
            DAT_HI: if (rx_valid) w_nextState = DAT_LO;
            DAT_LO: if (rx_valid) w_nextState = w_lastWord ? IDLE : DAT_HI;
            BP_HI:  if (rx_valid) w_nextState = BP_LO;
            BP_LO:  if (rx_valid) w_nextState = r_bpFromHalt ? HALT : IDLE;
            RUN: begin
                if (w_bpMatch || (rx_valid && rx_data == c_CMD_HALT)) w_nextState = HALT;
            end
            STEP:    w_nextState = HALT;
            default: w_nextState = IDLE;
        endcase
        if (w_timeoutAbort) w_nextState = IDLE;
    end

    always_comb begin
        cpu_reset = 1'b0;
        cpu_ce    = 1'b0;
        case (r_state)
            IDLE, CNT_HI, CNT_LO, DAT_HI, DAT_LO: cpu_reset = 1'b1;
            BP_HI, BP_LO:                         cpu_reset = !r_bpFromHalt;
            RUN:                                  cpu_ce    = !w_bpMatch;
            STEP:                                 cpu_ce    = 1'b1;
            default:                              cpu_reset = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hiByte     <= 8'd0;
            r_wordCnt    <= 16'd0;
            r_wordIdx    <= 16'd0;
            r_bpAddr     <= 16'd0;
            r_bpEn       <= 1'b0;
            r_bpFromHalt <= 1'b0;
            r_resume     <= 1'b0;
            r_loaded     <= 1'b0;
            r_loadErr    <= 1'b0;
            r_romWe      <= 1'b0;
            r_romAddr    <= '0;
            r_romWdata   <= 16'd0;
            r_bpHit      <= 1'b0;
        end else begin
            r_romWe  <= 1'b0;
            r_bpHit  <= 1'b0;
            r_resume <= 1'b0;
            case (r_state)
                IDLE, HALT: begin
                    if (rx_valid) begin
                        case (rx_data)
                            c_CMD_LOAD: begin
                                r_loaded  <= 1'b0;
                                r_loadErr <= 1'b0;
                            end
                            c_CMD_BP:    r_bpFromHalt <= (r_state == HALT);
                            c_CMD_RUN:   r_resume     <= (r_state == HALT);
                            c_CMD_CLRBP: r_bpEn       <= 1'b0;
                            default:     r_bpEn       <= r_bpEn;
                        endcase
                    end
                end
                CNT_HI, DAT_HI, BP_HI: if (rx_valid) r_hiByte <= rx_data;
                CNT_LO: begin
                    if (rx_valid) begin
                        r_wordCnt <= {r_hiByte, rx_data};
                        r_wordIdx <= 16'd0;
                        if ({r_hiByte, rx_data} == 16'd0) r_loaded <= 1'b1;
                    end
                end
                DAT_LO: begin
                    if (rx_valid) begin
                        // Words past the end of the ROM are consumed silently.
                        if (w_inRange) begin
                            r_romWe    <= 1'b1;
                            r_romAddr  <= r_wordIdx[ROM_AW-1:0];
                            r_romWdata <= {r_hiByte, rx_data};
                        end
                        r_wordIdx <= r_wordIdx + 16'd1;
                        if (w_lastWord) r_loaded <= 1'b1;
                    end
                end
                BP_LO: begin
                    if (rx_valid) begin
                        r_bpAddr <= {r_hiByte, rx_data};
                        r_bpEn   <= 1'b1;
                    end
                end
                RUN:     if (w_bpMatch) r_bpHit <= 1'b1;
                default: r_bpHit <= 1'b0;
            endcase
            if (w_timeoutAbort) begin
                r_loadErr <= 1'b1;
                if (w_inLoad) r_loaded <= 1'b0;
            end
        end
    end

    assign rom_we    = r_romWe;
    assign rom_addr  = r_romAddr;
    assign rom_wdata = r_romWdata;
    assign loaded    = r_loaded;
    assign load_err  = r_loadErr;
    assign bp_hit    = r_bpHit;
    assign running   = (r_state == RUN);
    assign halted    = (r_state == HALT);

endmodule

`default_nettype wire

// File: tb/tb_hack_run_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_hack_run_ctrl
// Description : Self-checking bench for hack_run_ctrl (vector table plus
//               ROM-write scoreboard and multi-cycle sequences).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_hack_run_ctrl;

    localparam int ROM_AW  = 2;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic [15:0]       cpu_pc;
    logic              cpu_reset, cpu_ce, rom_we, loaded, running, halted, load_err, bp_hit;
    logic [ROM_AW-1:0] rom_addr;
    logic [15:0]       rom_wdata;

    hack_run_ctrl #(.ROM_AW(ROM_AW), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .cpu_pc    (cpu_pc),
        .cpu_reset (cpu_reset),
        .cpu_ce    (cpu_ce),
        .rom_we    (rom_we),
        .rom_addr  (rom_addr),
        .rom_wdata (rom_wdata),
        .loaded    (loaded),
        .running   (running),
        .halted    (halted),
        .load_err  (load_err),
        .bp_hit    (bp_hit)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    // exp bits: {cpu_reset, cpu_ce, running, halted, loaded}
    typedef struct {
        logic [7:0]  data;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [4:0]  exp;
    } vec_t;

    wr_t  expQ[$];
    vec_t vecs[15];
    int   nCmp  = 0;
    int   nFail = 0;
    int   hits;
    logic ce, seen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        nCmp++;
        if (act !== req) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // One clock; any ROM write seen is matched against the scoreboard.
    task automatic tick();
        wr_t w;
        @(posedge clk);
        #1;
        if (rom_we) begin
            nCmp++;
            if (expQ.size() == 0) begin
                nFail++;
                $display("FAIL rom_write: got addr %0h data %h, expected no write", rom_addr, rom_wdata);
            end else begin
                w = expQ.pop_front();
                if (16'(rom_addr) !== w.addr || rom_wdata !== w.data) begin
                    nFail++;
                    $display("FAIL rom_write: got addr %0h data %h, expected addr %0h data %h",
                             rom_addr, rom_wdata, w.addr, w.data);
                end
            end
        end
    endtask

    task automatic sendByte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic doReset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic checkReset(input string tag);
        check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
        check({tag, "_cpu_ce"},    32'(cpu_ce),    32'd0);
        check({tag, "_rom_we"},    32'(rom_we),    32'd0);
        check({tag, "_rom_addr"},  32'(rom_addr),  32'd0);
        check({tag, "_rom_wdata"}, 32'(rom_wdata), 32'd0);
        check({tag, "_loaded"},    32'(loaded),    32'd0);
        check({tag, "_load_err"},  32'(load_err),  32'd0);
        check({tag, "_bp_hit"},    32'(bp_hit),    32'd0);
        check({tag, "_run_halt"},  32'({running, halted}), 32'd0);
    endtask

    // Bench-side CPU: pc advances on each edge where cpu_ce was high.
    task automatic runCpu(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            #1;
            ce = cpu_ce;
            if (cpu_pc == 16'd5 && running && !seen) begin
                check("bp_ce_at_pc5", 32'(cpu_ce), 32'd0);
                seen = 1'b1;
            end
            tick();
            if (ce) cpu_pc = cpu_pc + 16'd1;
            if (bp_hit) hits++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{8'h4C, 1'b0, 16'h0, 16'h0000, 5'b10000};
        vecs[1]  = '{8'h00, 1'b0, 16'h0, 16'h0000, 5'b10000};
        vecs[2]  = '{8'h02, 1'b0, 16'h0, 16'h0000, 5'b10000};
        vecs[3]  = '{8'h12, 1'b0, 16'h0, 16'h0000, 5'b10000};
        vecs[4]  = '{8'h34, 1'b1, 16'h0, 16'h1234, 5'b10000};
        vecs[5]  = '{8'hAB, 1'b0, 16'h0, 16'h0000, 5'b10000};
        vecs[6]  = '{8'hCD, 1'b1, 16'h1, 16'hABCD, 5'b10001};
        vecs[7]  = '{8'h99, 1'b0, 16'h0, 16'h0000, 5'b10001};
        vecs[8]  = '{8'h52, 1'b0, 16'h0, 16'h0000, 5'b01101};
        vecs[9]  = '{8'h4C, 1'b0, 16'h0, 16'h0000, 5'b01101};
        vecs[10] = '{8'h53, 1'b0, 16'h0, 16'h0000, 5'b01101};
        vecs[11] = '{8'h48, 1'b0, 16'h0, 16'h0000, 5'b00011};
        vecs[12] = '{8'h52, 1'b0, 16'h0, 16'h0000, 5'b01101};
        vecs[13] = '{8'h48, 1'b0, 16'h0, 16'h0000, 5'b00011};
        vecs[14] = '{8'h43, 1'b0, 16'h0, 16'h0000, 5'b00011};

        rx_valid = 1'b0;
        rx_data  = 8'h00;
        cpu_pc   = 16'd0;
        reset    = 1'b1;
        tick();
        doReset();
        checkReset("por");

        // Load two words, then exercise run/halt/ignored commands.
        for (int i = 0; i < 15; i++) begin
            if (vecs[i].wr) expQ.push_back('{vecs[i].addr, vecs[i].wdata});
            sendByte(vecs[i].data);
            check($sformatf("vec%0d", i), 32'({cpu_reset, cpu_ce, running, halted, loaded}),
                  32'(vecs[i].exp));
        end

        // Single step from HALT.
        sendByte(8'h53);
        check("step_ce", 32'({cpu_ce, halted}), 32'b10);
        tick();
        check("step_after", 32'({cpu_ce, halted}), 32'b01);

        // Overflow: 5 words into a 4-word ROM; last word is dropped.
        sendByte(8'h4C);
        check("load_clears_loaded", 32'({cpu_reset, loaded}), 32'b10);
        sendByte(8'h00);
        sendByte(8'h05);
        for (int i = 0; i < 5; i++) begin
            if (i < 4) expQ.push_back('{16'(i), {8'h10, 8'(i)}});
            sendByte(8'h10);
            sendByte(8'(i));
        end
        tick();
        check("ovf_loaded", 32'({loaded, halted, running}), 32'b100);
        check("ovf_drained", 32'(expQ.size()), 32'd0);

        // Zero-length load.
        sendByte(8'h4C);
        sendByte(8'h00);
        check("n0_loaded_low", 32'(loaded), 32'd0);
        sendByte(8'h00);
        check("n0_loaded", 32'({loaded, cpu_reset, running}), 32'b110);

        // Breakpoint at pc 5, set from IDLE.
        doReset();
        checkReset("rst2");
        sendByte(8'h42);
        check("bp_idle_cpu_reset", 32'(cpu_reset), 32'd1);
        sendByte(8'h00);
        sendByte(8'h05);
        check("bp_idle_return", 32'({cpu_reset, running, halted}), 32'b100);
        cpu_pc = 16'd0;
        hits   = 0;
        seen   = 1'b0;
        sendByte(8'h52);
        runCpu(12);
        check("bp_reached", 32'(seen), 32'd1);
        check("bp_hit_once", 32'(hits), 32'd1);
        check("bp_halted", 32'({halted, running}), 32'b10);
        check("bp_pc", 32'(cpu_pc), 32'd5);

        // Re-arm from HALT: CPU stays out of reset, returns to HALT.
        sendByte(8'h42);
        check("bp_halt_cpu_reset", 32'(cpu_reset), 32'd0);
        sendByte(8'h00);
        sendByte(8'h05);
        check("bp_halt_return", 32'(halted), 32'd1);

        // Resume runs past the breakpoint.
        hits = 0;
        seen = 1'b1;
        sendByte(8'h52);
        runCpu(4);
        check("resume_pc", 32'(cpu_pc), 32'd9);
        check("resume_no_hit", 32'(hits), 32'd0);
        check("resume_running", 32'(running), 32'd1);
        sendByte(8'h48);

        // Reset in the middle of a load.
        doReset();
        sendByte(8'h4C);
        sendByte(8'h00);
        sendByte(8'h03);
        sendByte(8'hAA);
        doReset();
        checkReset("midload");
        sendByte(8'h52);
        check("midload_run", 32'({running, cpu_reset, cpu_ce}), 32'b101);
        sendByte(8'h48);

        // 'C' clears the breakpoint: run passes pc 3.
        sendByte(8'h42);
        sendByte(8'h00);
        sendByte(8'h03);
        sendByte(8'h43);
        cpu_pc = 16'd0;
        hits   = 0;
        seen   = 1'b1;
        sendByte(8'h52);
        runCpu(6);
        check("clr_pc", 32'(cpu_pc), 32'd6);
        check("clr_no_hit", 32'({hits[0], running}), 32'b01);

        // Timeout mid-word.
        doReset();
        sendByte(8'h4C);
        sendByte(8'h00);
        sendByte(8'h01);
        sendByte(8'h12);
        repeat (15) tick();
        check("to_not_early", 32'(load_err), 32'd0);
        for (int i = 0; i < 5 && !load_err; i++) tick();
        check("to_load_err", 32'(load_err), 32'd1);
        check("to_state", 32'({loaded, cpu_reset, running, halted}), 32'b0100);
        check("final_drained", 32'(expQ.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hack_run_ctrl.md
HACK_RUN_CTRL -- requirements
Module: hack_run_ctrl

Interface
REQ-001 Parameter ROM_AW, default 15, instruction-ROM address width.
REQ-002 Parameter TIMEOUT, default 100000, idle cycles tolerated between bytes of a multi-byte command.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle.
REQ-006 rx_data  in  8  command or payload byte.
REQ-007 cpu_pc  in  16  current CPU program counter.
REQ-008 cpu_reset  out  1  holds the CPU in reset; active-high.
REQ-009 cpu_ce  out  1  CPU clock enable; the CPU advances one instruction per cycle while this is high.
REQ-010 rom_we  out  1  instruction-ROM write strobe.
REQ-011 rom_addr  out  ROM_AW  instruction-ROM write address.
REQ-012 rom_wdata  out  16  instruction word to write.
REQ-013 loaded, running, halted, load_err, bp_hit  out  1 each  status flags; bp_hit is a one-cycle pulse.

Function
REQ-014 The FSM SHALL have states IDLE, CNT_HI, CNT_LO, DAT_HI, DAT_LO, BP_HI, BP_LO, RUN, HALT, STEP.
REQ-015 Commands are accepted only in IDLE or HALT: 0x4C 'L' -> CNT_HI; 0x42 'B' -> BP_HI; 0x52 'R' -> RUN; 0x53 'S' -> STEP; 0x43 'C' clears bp_en.
REQ-016 In IDLE or HALT, any other byte SHALL be ignored.
REQ-017 In RUN, only 0x48 'H' is acted on (-> HALT); all other bytes SHALL be ignored.
REQ-018 Load sequence: CNT_HI and CNT_LO capture a 16-bit word count N, MSB first. DAT_HI and DAT_LO then capture each word, MSB first.
REQ-019 Load, N=0: after CNT_LO the FSM returns to IDLE, with loaded=1 and no ROM writes.
REQ-020 Load, write timing: rom_we pulses for exactly one cycle, in the cycle after the rx_valid carrying a low byte. rom_wdata={hi,lo}, and rom_addr equals the word index (starting at 0).
REQ-021 Load, completion: after word N-1 is written the FSM enters IDLE and sets loaded=1.
REQ-022 Load, overflow: words with index >= 2^ROM_AW are consumed but produce no rom_we.
REQ-023 cpu_reset SHALL be 1 in IDLE, CNT_*, DAT_*, and in BP_* entered from IDLE; it is 0 in RUN, HALT, STEP, and in BP_* entered from HALT.
REQ-024 cpu_ce SHALL be 1 only in RUN and STEP.
REQ-025 STEP SHALL last exactly one cycle and then enter HALT.
REQ-026 Breakpoint setup: BP_HI and BP_LO capture bp_addr (MSB first) and set bp_en=1. The FSM then returns to its originating state, IDLE or HALT.
REQ-027 Breakpoint hit: in RUN, with bp_en=1 and cpu_pc==bp_addr, cpu_ce SHALL be 0 in that same cycle (combinational). The FSM then enters HALT and bp_hit pulses for one cycle.
REQ-028 Breakpoint comparison SHALL be suppressed on the first RUN cycle after leaving HALT, so a resume executes the instruction at the breakpoint.
REQ-029 Breakpoint comparison SHALL never apply in STEP.
REQ-030 Simultaneous 'H' and breakpoint match in RUN: the FSM SHALL enter HALT, with bp_hit pulsing.
REQ-031 Timeout: a counter clears on every rx_valid and on entry to CNT_HI or BP_HI.
REQ-032 If the counter reaches TIMEOUT in any CNT_*, DAT_* or BP_* state, the FSM SHALL enter IDLE and set load_err=1. loaded is cleared if the abort occurred in CNT_* or DAT_*.
REQ-033 loaded SHALL clear on entry to CNT_HI; load_err SHALL clear on entry to CNT_HI.
REQ-034 running=1 iff the state is RUN; halted=1 iff the state is HALT.

Reset
REQ-035 On reset, state=IDLE and the following outputs SHALL be: cpu_reset=1, cpu_ce=0, rom_we=0, rom_addr=0, rom_wdata=0, loaded=0, load_err=0, bp_hit=0.
REQ-036 On reset, bp_en=0, bp_addr=0, the word index and N SHALL be 0, and the timeout counter SHALL be 0.
REQ-037 Reset asserted mid-load or mid-run SHALL abort immediately; partial ROM contents are left as written.

Structure
REQ-038 The state encoding and the command byte constants ('L','B','R','S','H','C') SHALL reside in the shared package hack_ctrl_pkg.
REQ-039 The timeout counter SHALL be the sub-module byte_timeout (inputs clear and enable; output expired).

Verification
REQ-040 Load: bytes 4C 00 02 12 34 AB CD -> rom_we at addr 0 with data 0x1234, then addr 1 with 0xABCD; loaded=1; cpu_reset=1 throughout.
REQ-041 Breakpoint: 42 00 05, then 52, with cpu_pc stepping 0..5 -> cpu_ce=0 in the cycle where pc==5; bp_hit pulses once; halted=1. A following 52 runs past pc 5.
REQ-042 Step: from HALT, send 53 -> cpu_ce high for exactly 1 cycle, then halted=1.
REQ-043 Timeout: with TIMEOUT=16, send 4C 00 01 12 and then stall for 16 cycles -> IDLE, load_err=1, loaded=0, no rom_we.
REQ-044 Reset mid-load: 4C 00 03 AA, then reset for 1 cycle -> all outputs at reset values; the next 52 enters RUN with cpu_reset=0.
REQ-045 Ignored commands: in RUN, send 4C -> no state change and cpu_ce stays 1.
